// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM encoding for the serial program loader.
package prog_loader_pkg;

    // Program BRAM geometry, shared with the BRAM wrapper.
    localparam int         PL_ADDR_W    = 11;
    localparam int         PL_DEPTH     = 2048;
    localparam logic [7:0] PL_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN_H = 3'd1,
        S_LEN_L = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_ERR   = 3'd5
    } pl_state_t;

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte idle watchdog: reloads on kick, counts down while enabled,
// and flags expiry once TIMEOUT_CYC-1 idle cycles have elapsed.
module prog_loader_timeout #(
    parameter int TIMEOUT_CYC = 27_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    output logic expire
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TOP   = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Reload on every received byte; otherwise tick down while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (kick) begin
            cnt_q <= TOP;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // A byte arriving in the same cycle always wins over expiry.
    always_comb begin
        expire = en && !kick && (cnt_q == '0);
    end

endmodule

// File: rtl/prog_loader.sv
// Framed serial image loader: SYNC, 16-bit BE length, payload, 8-bit sum.
// Payload goes to BRAM port B from address 0; CPU held in reset meanwhile.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W      = PL_ADDR_W,
    parameter int         DEPTH       = PL_DEPTH,
    parameter logic [7:0] SYNC_BYTE   = PL_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 27_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [7:0]        mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    pl_state_t         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [7:0]        din_q, din_d;
    logic              in_frame;
    logic              expire;

    assign in_frame = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                      (state_q == S_DATA)  || (state_q == S_CSUM);

    prog_loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_frame),
        .kick   (rx_valid),
        .expire (expire)
    );

    // State and datapath registers; BRAM port drive is registered here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            ad_q    <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            ad_q    <= ad_d;
            din_q   <= din_d;
        end
    end

    // Frame parser: next state, length/address/sum updates and write request.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        wr_d    = 1'b0;
        ad_d    = ad_q;
        din_d   = din_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_H;
                    hold_d  = 1'b1;
                end
            end
            S_LEN_H: begin
                if (rx_valid) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = S_LEN_L;
                end else if (expire) begin
                    state_d = S_ERR;
                end
            end
            S_LEN_L: begin
                if (rx_valid) begin
                    len_d  = {len_q[15:8], rx_data};
                    addr_d = '0;
                    sum_d  = '0;
                    // Reject empty images and anything that would overrun the BRAM.
                    if (len_d == 16'd0 || {1'b0, len_d} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (expire) begin
                    state_d = S_ERR;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    wr_d   = 1'b1;
                    ad_d   = addr_q;
                    din_d  = rx_data;
                    sum_d  = sum_q + rx_data;
                    addr_d = addr_q + ADDR_W'(1);
                    // Compare in 17 bits so a full-depth image terminates cleanly.
                    if ((17'(addr_q) + 17'd1) == {1'b0, len_q}) begin
                        state_d = S_CSUM;
                    end
                end else if (expire) begin
                    state_d = S_ERR;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (expire) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                // cpu_hold intentionally left set: only a good image releases the CPU.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_ce    = wr_q;
    assign mem_wre   = wr_q;
    assign mem_ad    = ad_q;
    assign mem_din   = din_q;
    assign cpu_hold  = hold_q;
    assign busy      = (state_q != S_IDLE);
    assign load_done = done_q;
    assign load_err  = (state_q == S_ERR);

endmodule
